shift_rotate_iter: RTL and testbench

- Parametrised, multi-cycle barrel shift/rotate unit for the execute stage.
- Replaces fixed 32-bit combinational shifters with a width-generic engine.
- Resolves LOG2W shift stages, STAGES_PER_CYCLE per clock, MSB count stage first.
- Adds logical/arithmetic/rotate modes, x86 CF/OF generation and valid/ready handshakes on both sides.

---
 rtl/shf_pkg.sv | 26 ++
 rtl/shift_stage.sv | 26 ++
 rtl/shift_rotate_iter.sv | 135 +++++++++++++
 tb/tb_shift_rotate_iter.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/shf_pkg.sv
// shf_pkg: op, state and stage-mode encodings shared by the iterative shift/rotate unit
package shf_pkg;
  localparam logic [2:0] SHF_SHL = 3'd0;
  localparam logic [2:0] SHF_SHR = 3'd1;
  localparam logic [2:0] SHF_SAR = 3'd2;
  localparam logic [2:0] SHF_ROL = 3'd3;
  localparam logic [2:0] SHF_ROR = 3'd4;
  localparam logic [2:0] SHF_RCL = 3'd5;
  localparam logic [2:0] SHF_RCR = 3'd6;
  localparam logic [2:0] SHF_RSV = 3'd7;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;
  // stage modes: SHR covers SAR (fill bit differs), ROL/ROR span WIDTH bits, RCL/RCR span WIDTH+1
  localparam logic [2:0] MD_SHL = 3'd0;
  localparam logic [2:0] MD_SHR = 3'd1;
  localparam logic [2:0] MD_ROL = 3'd2;
  localparam logic [2:0] MD_ROR = 3'd3;
  localparam logic [2:0] MD_RCL = 3'd4;
  localparam logic [2:0] MD_RCR = 3'd5;
  function automatic logic [2:0] op_mode(input logic [2:0] op);
    return (op == SHF_SHR || op == SHF_SAR) ? MD_SHR :
           op == SHF_ROL ? MD_ROL :
           op == SHF_ROR ? MD_ROR :
           op == SHF_RCL ? MD_RCL :
           op == SHF_RCR ? MD_RCR : MD_SHL;
  endfunction
endpackage

// File: rtl/shift_stage.sv
// shift_stage: one log-shifter layer over the WIDTH+1 guard-extended vector
module shift_stage import shf_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int DW = 5
) (
  input  logic [WIDTH:0]   i_vec,
  input  logic [DW-1:0]    i_dist,
  input  logic [2:0]       i_mode,
  input  logic             i_fill,
  output logic [WIDTH:0]   o_vec
);
  logic [WIDTH-1:0] w_lo, w_rol, w_ror;
  logic [WIDTH:0]   w_shr, w_rcl, w_rcr;
  assign w_lo  = i_vec[WIDTH-1:0];
  assign w_rol = (w_lo << i_dist) | (w_lo >> (WIDTH - int'(i_dist)));
  assign w_ror = (w_lo >> i_dist) | (w_lo << (WIDTH - int'(i_dist)));
  assign w_rcl = (i_vec << i_dist) | (i_vec >> (WIDTH + 1 - int'(i_dist)));
  assign w_rcr = (i_vec >> i_dist) | (i_vec << (WIDTH + 1 - int'(i_dist)));
  assign w_shr = (i_vec >> i_dist) | (i_fill ? ~({(WIDTH+1){1'b1}} >> i_dist) : '0);
  always_comb
    o_vec = i_mode == MD_SHL ? i_vec << i_dist :
            i_mode == MD_SHR ? w_shr :
            i_mode == MD_ROL ? {i_vec[WIDTH], w_rol} :
            i_mode == MD_ROR ? {i_vec[WIDTH], w_ror} :
            i_mode == MD_RCL ? w_rcl : w_rcr;
endmodule

// File: rtl/shift_rotate_iter.sv
// shift_rotate_iter: multi-cycle barrel shift/rotate with x86 CF/OF and valid/ready on both sides.
// Define SHIFT_ROTATE_CARRY_EN to enable RCL/RCR; otherwise ops 5/6 pass data through.
module shift_rotate_iter import shf_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int STAGES_PER_CYCLE = 2,
  parameter int LOG2W = $clog2(WIDTH),
  parameter int NUM_ITER = (LOG2W + STAGES_PER_CYCLE - 1) / STAGES_PER_CYCLE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [LOG2W-1:0] in_cnt,
  input  logic [2:0]       in_op,
  input  logic             in_cf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_cf,
  output logic             out_of,
  output logic             out_cnt_zero,
  output logic             busy
);
  localparam int IW = $clog2(NUM_ITER + 1);
  state_t           r_state;
  logic [WIDTH:0]   r_vec;
  logic [WIDTH-1:0] r_data, r_res;
  logic [LOG2W-1:0] r_cnt;
  logic [2:0]       r_op, r_mode;
  logic [IW-1:0]    r_iter;
  logic             r_fill, r_valid, r_cf, r_of, r_cz;
  logic [WIDTH:0]   w_chain [STAGES_PER_CYCLE+1];
  logic [LOG2W-1:0] w_dist [STAGES_PER_CYCLE];
  int               w_pos [STAGES_PER_CYCLE];
  logic [WIDTH:0]   w_fin;
  logic [WIDTH-1:0] w_res;
  logic             w_cf, w_of, w_cz, w_pass, w_take;
  assign w_chain[0] = r_vec;
  assign w_fin = w_chain[STAGES_PER_CYCLE];
  // each iteration resolves the next count bits MSB-first; positions below bit 0 stay idle
  for (genvar j = 0; j < STAGES_PER_CYCLE; j++) begin : g_st
    assign w_pos[j] = LOG2W - 1 - int'(r_iter) * STAGES_PER_CYCLE - j;
    assign w_dist[j] = (w_pos[j] >= 0) ? (r_cnt & LOG2W'(1 << w_pos[j])) : '0;
    shift_stage #(.WIDTH(WIDTH), .DW(LOG2W)) u_stage (
      .i_vec (w_chain[j]),
      .i_dist(w_dist[j]),
      .i_mode(r_mode),
      .i_fill(r_fill),
      .o_vec (w_chain[j+1])
    );
  end
  assign w_cz = r_cnt == '0;
`ifdef SHIFT_ROTATE_CARRY_EN
  assign w_pass = w_cz | (r_op == SHF_RSV);
`else
  assign w_pass = w_cz | (r_op == SHF_RSV) | (r_op == SHF_RCL) | (r_op == SHF_RCR);
`endif
  always_comb begin
    w_res = w_fin[WIDTH-1:0];
    w_cf = 1'b0;
    w_of = 1'b0;
    case (r_op)
      SHF_SHL: begin w_cf = w_fin[WIDTH]; w_of = w_fin[WIDTH-1] ^ w_fin[WIDTH]; end
      SHF_SHR: begin w_res = w_fin[WIDTH:1]; w_cf = w_fin[0]; w_of = r_data[WIDTH-1]; end
      SHF_SAR: begin w_res = w_fin[WIDTH:1]; w_cf = w_fin[0]; end
      SHF_ROL: begin w_cf = w_fin[0]; w_of = w_fin[WIDTH-1] ^ w_fin[0]; end
      SHF_ROR: begin w_cf = w_fin[WIDTH-1]; w_of = w_fin[WIDTH-1] ^ w_fin[WIDTH-2]; end
      SHF_RCL: begin w_cf = w_fin[WIDTH]; w_of = w_fin[WIDTH-1] ^ w_fin[WIDTH]; end
      SHF_RCR: begin w_cf = w_fin[WIDTH]; w_of = w_fin[WIDTH-1] ^ w_fin[WIDTH-2]; end
      default: ;
    endcase
    if (w_pass) begin
      w_res = r_data;
      w_cf = 1'b0;
      w_of = 1'b0;
    end
  end
  assign in_ready = (r_state == ST_IDLE) | ((r_state == ST_DONE) & out_ready);
  assign w_take = in_valid & in_ready;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_valid <= 1'b0;
      r_res   <= '0;
      r_cf    <= 1'b0;
      r_of    <= 1'b0;
      r_cz    <= 1'b0;
      r_vec   <= '0;
      r_data  <= '0;
      r_cnt   <= '0;
      r_op    <= '0;
      r_mode  <= '0;
      r_fill  <= 1'b0;
      r_iter  <= '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          r_vec  <= w_fin;
          r_iter <= r_iter + IW'(1);
          if (r_iter == IW'(NUM_ITER - 1)) begin
            r_state <= ST_DONE;
            r_valid <= 1'b1;
            r_res   <= w_res;
            r_cf    <= w_cf;
            r_of    <= w_of;
            r_cz    <= w_cz;
          end
        end
        ST_DONE: if (out_ready) begin
          r_state <= ST_IDLE;
          r_valid <= 1'b0;
        end
        default: ;
      endcase
      // a capture in DONE overrides the retire-to-IDLE above so no bubble is inserted
      if (w_take) begin
        r_state <= ST_RUN;
        r_data  <= in_data;
        r_cnt   <= in_cnt;
        r_op    <= in_op;
        r_mode  <= op_mode(in_op);
        r_fill  <= (in_op == SHF_SAR) & in_data[WIDTH-1];
        r_iter  <= '0;
        r_vec   <= op_mode(in_op) == MD_SHR ? {in_data, 1'b0} :
                   {((in_op == SHF_RCL) | (in_op == SHF_RCR)) & in_cf, in_data};
      end
    end
  assign out_valid    = r_valid;
  assign out_data     = r_res;
  assign out_cf       = r_cf;
  assign out_of       = r_of;
  assign out_cnt_zero = r_cz;
  assign busy         = r_state != ST_IDLE;
endmodule

// File: tb/tb_shift_rotate_iter.sv
// tb_shift_rotate_iter: scoreboard bench for shift_rotate_iter (WIDTH=32, STAGES_PER_CYCLE=2)
module tb_shift_rotate_iter;
`ifdef SHIFT_ROTATE_CARRY_EN
  localparam bit CARRY = 1'b1;
`else
  localparam bit CARRY = 1'b0;
`endif
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready, in_cf = 1'b0;
  logic [31:0] in_data = '0, out_data;
  logic [4:0]  in_cnt = '0;
  logic [2:0]  in_op = '0;
  logic        out_valid, out_ready = 1'b1, out_cf, out_of, out_cnt_zero, busy;
  int          errors = 0, checks = 0, cyc = 0;
  bit          prev_v = 1'b0, rnd_bp = 1'b0;
  logic [34:0] exp_q [$];
  int          acc_q [$];

  shift_rotate_iter dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_cnt(in_cnt), .in_op(in_op), .in_cf(in_cf),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_cf(out_cf), .out_of(out_of), .out_cnt_zero(out_cnt_zero), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference result packed as {cnt_zero, of, cf, data}
  function automatic logic [34:0] model(input logic [2:0] op, input logic [31:0] d,
                                        input logic [4:0] c, input logic ci);
    logic [31:0] r;
    logic [32:0] v;
    logic cf, of;
    int n;
    n = int'(c);
    r = d;
    cf = 1'b0;
    of = 1'b0;
    if (n == 0 || op == 3'd7 || (!CARRY && op >= 3'd5)) return {n == 0, 2'b00, d};
    case (op)
      3'd0: begin r = d << n; cf = d[32-n]; of = r[31] ^ cf; end
      3'd1: begin r = d >> n; cf = d[n-1]; of = d[31]; end
      3'd2: begin r = 32'($signed(d) >>> n); cf = d[n-1]; end
      3'd3: begin r = (d << n) | (d >> (32 - n)); cf = r[0]; of = r[31] ^ cf; end
      3'd4: begin r = (d >> n) | (d << (32 - n)); cf = r[31]; of = r[31] ^ r[30]; end
      default: begin
        v = {ci, d};
        for (int i = 0; i < n; i++) v = (op == 3'd5) ? {v[31:0], v[32]} : {v[0], v[32:1]};
        r = v[31:0];
        cf = v[32];
        of = (op == 3'd5) ? r[31] ^ cf : r[31] ^ r[30];
      end
    endcase
    return {1'b0, of, cf, r};
  endfunction

  // handshakes sampled mid-cycle: both will complete on the coming rising edge
  always @(negedge clk) begin
    #2;
    if (!rst_n) prev_v = 1'b0;
    else begin
      if (out_valid && !prev_v) begin
        if (acc_q.size() == 0) chk("spurious_valid", 1, 0);
        else chk("latency", cyc - acc_q[0], 3);
      end
      prev_v = out_valid;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_result", 1, 0);
        else begin
          logic [34:0] e;
          e = exp_q.pop_front();
          void'(acc_q.pop_front());
          chk("data", out_data, e[31:0]);
          chk("cf", out_cf, e[32]);
          chk("of", out_of, e[33]);
          chk("cnt_zero", out_cnt_zero, e[34]);
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_op, in_data, in_cnt, in_cf));
        acc_q.push_back(cyc + 1);
      end
    end
  end

  always @(negedge clk) if (rnd_bp) out_ready = 1'($urandom_range(0, 1));

  task automatic send(input logic [2:0] op, input logic [31:0] d, input logic [4:0] c, input logic ci);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1; in_op = op; in_data = d; in_cnt = c; in_cf = ci;
    #1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  logic [2:0]  t_op [9] = '{3'd0, 3'd2, 3'd1, 3'd3, 3'd4, 3'd0, 3'd7, 3'd5, 3'd6};
  logic [31:0] t_d  [9] = '{32'h80000001, 32'h80000000, 32'h80000000, 32'h80000000, 32'h00000001,
                            32'h1234ABCD, 32'hDEADBEEF, 32'h0F0F0F0F, 32'hF0000001};
  logic [4:0]  t_c  [9] = '{5'd1, 5'd31, 5'd31, 5'd1, 5'd4, 5'd0, 5'd7, 5'd3, 5'd5};

  initial begin
    logic [34:0] e;
    int n;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_data", out_data, 0);
    chk("rst_flags", {out_cf, out_of, out_cnt_zero}, 0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 9; i++) send(t_op[i], t_d[i], t_c[i], 1'b1);
    drain();
    // back-pressure: result must hold while out_ready is low
    @(negedge clk) out_ready = 1'b0;
    send(3'd0, 32'h0000FFFF, 5'd8, 1'b0);
    e = model(3'd0, 32'h0000FFFF, 5'd8, 1'b0);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid", out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk("bp_data_hold", out_data, e[31:0]);
      chk("bp_flags_hold", {out_cf, out_of}, e[33:32]);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_valid_hold", out_valid, 1);
    end
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b1; in_op = 3'd4; in_data = 32'hA5A5000F; in_cnt = 5'd12; in_cf = 1'b0;
    #1 chk("bp_same_edge_ready", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk("bp_captured_busy", busy, 1);
    chk("bp_retired_valid", out_valid, 0);
    drain();
    rnd_bp = 1'b1;
    for (int i = 0; i < 30; i++)
      send(3'($urandom_range(0, 7)), $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
    rnd_bp = 1'b0;
    @(negedge clk) out_ready = 1'b1;
    drain();
    // reset while RUN at iter=1
    send(3'd3, 32'h12345678, 5'd9, 1'b0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midrun_rst_valid", out_valid, 0);
    chk("midrun_rst_busy", busy, 0);
    chk("midrun_rst_ready", in_ready, 1);
    exp_q.delete();
    acc_q.delete();
    @(negedge clk) rst_n = 1'b1;
    send(3'd2, 32'h80F00000, 5'd20, 1'b0);
    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
